// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack handshake and applies jump/branch redirects.
// Optional `FETCH_PERF_EN adds fetch and redirect performance counters.
module instr_fetch_unit #(
    parameter int unsigned            ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic [1:0]        jump,
    input  logic [25:0]       jump_index,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_offset,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_redir_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;

    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] next_pc;
    logic              redirect;
    logic              accept;
    logic              consume;

    assign pc_seq = pc_out_q + ADDR_W'(4);

    // Jump (jr or j/jal) beats a taken branch; jump=11 behaves like sequential.
    always_comb begin
        next_pc  = pc_seq;
        redirect = 1'b0;
        if (jump == 2'b10) begin
            next_pc  = jr_target & ~ADDR_W'(3);
            redirect = 1'b1;
        end else if (jump == 2'b01) begin
            next_pc  = {pc_seq[ADDR_W-1:ADDR_W-4], jump_index, 2'b00};
            redirect = 1'b1;
        end else if (branch_taken) begin
            next_pc  = pc_seq + (branch_offset << 2);
            redirect = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_out_d   = pc_out_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        imem_req   = 1'b0;
        accept     = 1'b0;
        consume    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    accept   = 1'b1;
                    instr_d  = imem_rdata;
                    pc_out_d = fetch_pc_q;
                    valid_d  = 1'b1;
                    state_d  = VALID;
                end
            end
            VALID: begin
                if (!stall) begin
                    consume    = 1'b1;
                    fetch_pc_d = next_pc;
                    valid_d    = 1'b0;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pc_out_q   <= RESET_PC;
            instr_q    <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_out_q   <= pc_out_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_seq;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] redir_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (accept) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (consume && redirect) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_redir_cnt = redir_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level PC model checked every cycle plus directed literal checks.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic [1:0]  jump;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redir_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit check_en = 1'b0;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .opcode        (opcode),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_redir_cnt(perf_redir_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a pending fetch address, the instruction currently held, and counters.
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    bit          m_started;
    bit          m_fetching;
    bit          m_have;
    int unsigned m_fetch_cnt;
    int unsigned m_redir_cnt;

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [1:0] j,
                                               input logic [25:0] idx, input logic [31:0] jr,
                                               input logic bt, input logic [31:0] off,
                                               output bit redir);
        logic [31:0] seq;
        seq   = pc + 32'd4;
        redir = 1'b1;
        if (j == 2'b10)      return jr - (jr % 4);
        else if (j == 2'b01) return (seq & 32'hF000_0000) + {6'd0, idx} * 4;
        else if (bt)         return seq + off * 4;
        redir = 1'b0;
        return seq;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_addr      = 32'h0;
            m_instr     = 32'h0;
            m_pc        = 32'h0;
            m_started   = 1'b0;
            m_fetching  = 1'b0;
            m_have      = 1'b0;
            m_fetch_cnt = 0;
            m_redir_cnt = 0;
        end else if (!m_started) begin
            m_started  = 1'b1;
            m_fetching = 1'b1;
        end else if (m_fetching) begin
            if (imem_ack) begin
                m_instr    = imem_rdata;
                m_pc       = m_addr;
                m_have     = 1'b1;
                m_fetching = 1'b0;
                m_fetch_cnt++;
            end
        end else if (m_have && !stall) begin
            bit r;
            m_addr     = model_next(m_pc, jump, jump_index, jr_target, branch_taken, branch_offset, r);
            m_have     = 1'b0;
            m_fetching = 1'b1;
            if (r) m_redir_cnt++;
        end
    end

    always @(negedge clk) begin
        if (check_en && rst_n) begin
            chk("imem_req", {31'd0, imem_req}, {31'd0, m_fetching});
            if (m_fetching) chk("imem_addr", imem_addr, m_addr);
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
            chk("instr", instr, m_instr);
            chk("opcode", {26'd0, opcode}, {26'd0, m_instr[31:26]});
            chk("pc_out", pc_out, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
`ifdef FETCH_PERF_EN
            chk("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
            chk("perf_redir_cnt", perf_redir_cnt, m_redir_cnt);
`endif
        end
    end

    task automatic junk_redirect();
        jump          = 2'b10;
        jump_index    = 26'h3FF_FFFF;
        jr_target     = 32'hFFFF_0000;
        branch_taken  = 1'b1;
        branch_offset = 32'd5;
    endtask

    task automatic wait_req();
        int w = 0;
        while (!imem_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] data, input int delay, output logic [31:0] addr);
        wait_req();
        addr = imem_addr;
        repeat (delay) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic consume(input int hold, input logic [1:0] j, input logic [25:0] idx,
                           input logic [31:0] jr, input logic bt, input logic [31:0] off);
        stall = 1'b1;
        junk_redirect();
        repeat (hold) @(negedge clk);
        jump          = j;
        jump_index    = idx;
        jr_target     = jr;
        branch_taken  = bt;
        branch_offset = off;
        stall         = 1'b0;
        @(negedge clk);
        stall = 1'b1;
        junk_redirect();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] held_instr;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b1;
        junk_redirect();
        #13;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_opcode", {26'd0, opcode}, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_pc_plus4", pc_plus4, 32'd4);
        @(negedge clk);
        rst_n    = 1'b1;
        check_en = 1'b1;

        // Same-cycle ack, decode fields, and hold under stall.
        do_fetch(32'h8C08_0004, 0, a);
        chk("t1_addr", a, 32'h0);
        chk("t1_opcode", {26'd0, opcode}, {26'd0, 6'b100011});
        chk("t1_instr", instr, 32'h8C08_0004);
        chk("t1_pc_out", pc_out, 32'h0);
        chk("t1_pc_plus4", pc_plus4, 32'h4);
        held_instr = instr;
        consume(3, 2'b00, 26'h0, 32'h0, 1'b0, 32'h0);
        chk("t2_held_instr", instr, held_instr);

        do_fetch(32'h2001_0001, 0, a);
        chk("t2_addr4", a, 32'h4);
        consume(0, 2'b00, 26'h0, 32'h0, 1'b0, 32'h0);
        do_fetch(32'h2001_0002, 0, a);
        chk("t2_addr8", a, 32'h8);
        consume(0, 2'b10, 26'h0, 32'h0000_0100, 1'b0, 32'h0);

        // Branches around 0x100.
        do_fetch(32'h1000_FFFE, 0, a);
        chk("t3_jr_0x100", a, 32'h0000_0100);
        consume(0, 2'b00, 26'h0, 32'h0, 1'b1, 32'hFFFF_FFFE);
        do_fetch(32'h0000_0000, 0, a);
        chk("t3_branch_neg", a, 32'h0000_00FC);
        consume(0, 2'b10, 26'h0, 32'h0000_0100, 1'b0, 32'h0);
        do_fetch(32'h1000_0003, 1, a);
        chk("t3_jr_0x100b", a, 32'h0000_0100);
        consume(0, 2'b00, 26'h0, 32'h0, 1'b1, 32'h0000_0003);
        do_fetch(32'h0000_0000, 0, a);
        chk("t3_branch_pos", a, 32'h0000_0110);

        // Jumps: index target keeps upper nibble, jump beats branch, jr clears low bits.
        consume(0, 2'b10, 26'h0, 32'h4000_0000, 1'b0, 32'h0);
        do_fetch(32'h0800_0010, 0, a);
        chk("t4_jr_0x4000", a, 32'h4000_0000);
        consume(2, 2'b01, 26'h10, 32'h0, 1'b1, 32'h0000_0100);
        do_fetch(32'h0000_0000, 0, a);
        chk("t4_jidx", a, 32'h4000_0040);
        consume(0, 2'b10, 26'h0, 32'h0000_1237, 1'b1, 32'h0000_0100);
        do_fetch(32'h0000_0000, 0, a);
        chk("t4_jr_align", a, 32'h0000_1234);

        // Wrap at top of address space; jump=11 acts as sequential.
        consume(0, 2'b10, 26'h0, 32'hFFFF_FFFC, 1'b0, 32'h0);
        do_fetch(32'h0000_0000, 0, a);
        chk("wrap_top", a, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        consume(0, 2'b11, 26'h155, 32'h0000_1000, 1'b0, 32'h0);
        do_fetch(32'h0000_0000, 0, a);
        chk("wrap_seq_j11", a, 32'h0);

        // Delayed ack, then reset in the middle of a wait.
        consume(0, 2'b00, 26'h0, 32'h0, 1'b0, 32'h0);
        do_fetch(32'hAC00_0000, 5, a);
        chk("t5_delay_addr", a, 32'h4);
        chk("t5_delay_pc", pc_out, 32'h4);
        consume(0, 2'b00, 26'h0, 32'h0, 1'b0, 32'h0);
        wait_req();
        repeat (3) @(negedge clk);
        chk("t5_req_before_rst", {31'd0, imem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_req_dropped", {31'd0, imem_req}, 32'd0);
        chk("t5_rst_pc", pc_out, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        @(negedge clk);
        chk("t5_stale_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_restart_req", {31'd0, imem_req}, 32'd1);
        chk("t5_restart_addr", imem_addr, 32'h0);

        // Four fetches including one jump (counter scenario when enabled).
        do_fetch(32'h0000_0001, 0, a);
        chk("t6_addr0", a, 32'h0);
        consume(0, 2'b00, 26'h0, 32'h0, 1'b0, 32'h0);
        do_fetch(32'h0800_0040, 0, a);
        chk("t6_addr4", a, 32'h4);
        consume(0, 2'b01, 26'h40, 32'h0, 1'b0, 32'h0);
        do_fetch(32'h0000_0003, 0, a);
        chk("t6_jump_addr", a, 32'h0000_0100);
        consume(0, 2'b00, 26'h0, 32'h0, 1'b0, 32'h0);
        do_fetch(32'h0000_0004, 0, a);
        chk("t6_seq_addr", a, 32'h0000_0104);
`ifdef FETCH_PERF_EN
        chk("t6_perf_fetch", perf_fetch_cnt, 32'd4);
        chk("t6_perf_redir", perf_redir_cnt, 32'd1);
`endif
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
